// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search block.
// SAR_EARLY_EXIT_EN (in sar_search) enables finishing on an early comparator hit.
package sar_pkg;

    localparam int SAR_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRIAL,
        ST_VERIFY,
        ST_DONE
    } state_t;

    function automatic logic flags_onehot(
        input logic eq,
        input logic lt,
        input logic gt
    );
        return (eq ^ lt ^ gt) & ~(eq & lt & gt);
    endfunction

endpackage

// File: rtl/sar_flag_chk.sv
// Combinational check that exactly one comparator flag is asserted.
// Protocol violations are detected here and reported by sar_search.
module sar_flag_chk
    import sar_pkg::*;
(
    input  logic eq,
    input  logic lt,
    input  logic gt,
    output logic onehot_ok
);

    assign onehot_ok = flags_onehot(eq, lt, gt);

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search driving an external comparator.
// Define SAR_EARLY_EXIT_EN to finish as soon as a trial hits equality.
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    input  logic             cmp_gt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] guess_d;
    logic [WIDTH-1:0] result_d;
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    idx_d;
    logic             found_d;
    logic             err_d;
    logic             done_d;
    logic             onehot_ok;

    sar_flag_chk u_flag_chk (
        .eq        (cmp_eq),
        .lt        (cmp_lt),
        .gt        (cmp_gt),
        .onehot_ok (onehot_ok)
    );

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        guess_d  = guess;
        idx_d    = idx_q;
        result_d = result;
        found_d  = found;
        err_d    = err;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    guess_d            = '0;
                    guess_d[WIDTH-1]   = 1'b1;
                    idx_d              = IW'(WIDTH - 1);
                    found_d            = 1'b0;
                    err_d              = 1'b0;
                    state_d            = ST_TRIAL;
                end
            end
            ST_TRIAL: begin
                if (!onehot_ok) begin
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = guess;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
`ifdef SAR_EARLY_EXIT_EN
                else if (cmp_eq) begin
                    result_d = guess;
                    found_d  = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
`endif
                else begin
                    // eq and gt both keep the trial bit
                    if (cmp_lt) begin
                        guess_d[idx_q] = 1'b0;
                    end
                    if (idx_q != '0) begin
                        guess_d[idx_q - IW'(1)] = 1'b1;
                        idx_d                   = idx_q - IW'(1);
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
            end
            ST_VERIFY: begin
                if (!onehot_ok) begin
                    err_d   = 1'b1;
                    found_d = 1'b0;
                end else begin
                    err_d   = 1'b0;
                    found_d = cmp_eq;
                end
                result_d = guess;
                done_d   = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            guess   <= '0;
            idx_q   <= '0;
            result  <= '0;
            found   <= 1'b0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            guess   <= guess_d;
            idx_q   <= idx_d;
            result  <= result_d;
            found   <= found_d;
            err     <= err_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search with a behavioural comparator.
// Expected values come from a binary-search model of the target.
module tb_sar_search;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] guess;
    logic [W-1:0] result;
    logic         cmp_eq, cmp_lt, cmp_gt;
    logic         busy, done, found, err;

    logic [W-1:0] target = '0;
    logic         force_en = 1'b0;
    logic [2:0]   force_flags = 3'b000;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        if (force_en) begin
            {cmp_eq, cmp_lt, cmp_gt} = force_flags;
        end else begin
            cmp_eq = (target == guess);
            cmp_lt = (target < guess);
            cmp_gt = (target > guess);
        end
    end

    sar_search #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .guess  (guess),
        .cmp_eq (cmp_eq),
        .cmp_lt (cmp_lt),
        .cmp_gt (cmp_gt),
        .busy   (busy),
        .done   (done),
        .result (result),
        .found  (found),
        .err    (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_guess"}, guess, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_found"}, found, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Called at a negedge; start is sampled at the next posedge (cycle 0).
    // bad: cycle whose flags are forced to {eq,lt,gt}=110 (0 = none)
    // again: cycle in which start is re-asserted (0 = none)
    // rstc: cycle in which rst_n is pulled low (0 = none)
    task automatic run(input int tgt, input int bad, input int again,
                       input int rstc);
        int seq[W];
        int hit;
        int exp_done;
        int exp_res;
        int exp_found;
        int exp_err;
        int n;
        bit seen;
        target = tgt[W-1:0];
        force_flags = 3'b110;
        hit = 0;
        for (int i = 0; i < W; i++) begin
            seq[i] = (tgt & ~((1 << (W - i)) - 1)) | (1 << (W - 1 - i));
`ifdef SAR_EARLY_EXIT_EN
            if (hit == 0 && seq[i] == tgt) hit = i + 1;
`endif
        end
        if (bad > 0 && (hit == 0 || bad <= hit)) begin
            exp_done  = bad + 1;
            exp_res   = (bad <= W) ? seq[bad-1] : tgt;
            exp_found = 0;
            exp_err   = 1;
        end else if (hit > 0) begin
            exp_done  = hit + 1;
            exp_res   = tgt;
            exp_found = 1;
            exp_err   = 0;
        end else begin
            exp_done  = W + 2;
            exp_res   = tgt;
            exp_found = 1;
            exp_err   = 0;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        seen = 1'b0;
        while (n <= W + 3 && !seen) begin
            force_en = (n == bad);
            start = (n == again);
            if (n <= W && n < exp_done)
                chk($sformatf("t%0d_guess_c%0d", tgt, n), guess, seq[n-1]);
            if (n == rstc) begin
                rst_n = 1'b0;
                force_en = 1'b0;
                start = 1'b0;
                #1;
                chk_idle_zero("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            chk($sformatf("t%0d_busy_c%0d", tgt, n), busy, 1);
            chk($sformatf("t%0d_done_c%0d", tgt, n), done, n == exp_done);
            if (done) begin
                seen = 1'b1;
                chk($sformatf("t%0d_result", tgt), result, exp_res);
                chk($sformatf("t%0d_found", tgt), found, exp_found);
                chk($sformatf("t%0d_err", tgt), err, exp_err);
                chk($sformatf("t%0d_guess_done", tgt), guess, exp_res);
            end
            @(negedge clk);
            n++;
        end
        force_en = 1'b0;
        start = 1'b0;
        if (!seen) begin
            chk($sformatf("t%0d_done_timeout", tgt), 0, 1);
            return;
        end
        chk($sformatf("t%0d_done_low_after", tgt), done, 0);
        chk($sformatf("t%0d_busy_low_after", tgt), busy, 0);
        chk($sformatf("t%0d_result_held", tgt), result, exp_res);
        chk($sformatf("t%0d_guess_held", tgt), guess, exp_res);
    endtask

    initial begin
        int t;
        #1;
        chk_idle_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(0, 0, 0, 0);
        run(15, 0, 0, 0);
`ifdef SAR_EARLY_EXIT_EN
        run(8, 0, 0, 0);
`endif
        run(5, 2, 0, 0);
        run(9, 0, 2, 3);
        run(9, 0, 0, 0);

        for (int k = 0; k < 20; k++) begin
            t = int'($urandom_range(0, (1 << W) - 1));
            run(t, 0, 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int k = 0; k < 8; k++) begin
            t = int'($urandom_range(0, (1 << W) - 1));
            run(t, int'($urandom_range(1, W + 1)), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 guess  output  WIDTH  trial operand driven to the external comparator's B input; the comparator's A input is the unknown target.
REQ-006 cmp_eq  input  1  comparator flag, A==B, combinational from guess.
REQ-007 cmp_lt  input  1  comparator flag, A<B.
REQ-008 cmp_gt  input  1  comparator flag, A>B.
REQ-009 busy  output  1  high in every non-IDLE state.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 result  output  WIDTH  final search value; valid while done=1 and held until the next start.
REQ-012 found  output  1  cmp_eq was observed on result; valid with done.
REQ-013 err  output  1  flag protocol violation seen; valid with done.

Function
REQ-014 States: IDLE, TRIAL, VERIFY, DONE; IDLE is the reset state.
REQ-015 IDLE with start=1: guess <= 1<<(WIDTH-1), bit index <= WIDTH-1, next state TRIAL; start in any other state is ignored.
REQ-016 TRIAL: flags are sampled once per cycle against the current registered guess; cmp_lt=1 clears guess[idx]; cmp_gt=1 or cmp_eq=1 keeps guess[idx]; if idx>0, guess[idx-1] is set and idx is decremented.
REQ-017 TRIAL at idx=0 moves to VERIFY with guess holding the completed SAR value.
REQ-018 VERIFY: found <= cmp_eq, result <= guess, next state DONE.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in DONE.
REQ-020 Flag check in TRIAL and VERIFY: any cycle where the number of asserted flags is not exactly one sets err=1, found=0, result=guess, and the next state is DONE (abort).
REQ-021 Nominal latency: start sampled in cycle 0; TRIAL in cycles 1..WIDTH; VERIFY in cycle WIDTH+1; done in cycle WIDTH+2.
REQ-022 Targets 0 and 2^WIDTH-1 are reached by the normal procedure, with no special-case logic.
REQ-023 guess holds its last value while in IDLE and DONE.

Reset
REQ-024 rst_n low forces IDLE immediately, including mid-search.
REQ-025 Reset values: guess=0, result=0, busy=0, done=0, found=0, err=0, idx=0.
REQ-026 The first start is accepted on the first rising edge at which rst_n is high.

Configuration
REQ-027 Macro SAR_EARLY_EXIT_EN defined: cmp_eq=1 in TRIAL (one-hot valid) sets result=guess, found=1 and goes directly to DONE, so done arrives in cycle k+1 for a hit in TRIAL cycle k.
REQ-028 SAR_EARLY_EXIT_EN undefined: cmp_eq in TRIAL is treated as a keep; the search always takes WIDTH+2 cycles.

Structure
REQ-029 Shared package sar_pkg holds the state enum, the WIDTH default constant and the flag-onehot check function.
REQ-030 One sub-module, sar_flag_chk: combinational, {eq,lt,gt} in, onehot_ok out; instantiated once.
REQ-031 Target size: 120-400 lines of RTL; no latches; all outputs registered except busy, which is decoded from state.

Verification
REQ-032 Bench pairs the DUT with a behavioural 4-bit comparator (A=target, B=guess). Macro undefined, WIDTH=4, target=0: guesses 8,4,2,1; done in cycle 6; result=0, found=1, err=0.
REQ-033 Macro undefined, target=15: guesses 8,12,14,15; result=15, found=1; done in cycle 6.
REQ-034 Macro defined, target=8: first TRIAL sees eq; done in cycle 2; result=8, found=1.
REQ-035 Target=5, comparator forced to flags {1,1,0} in the second TRIAL: done in the following cycle; err=1, found=0.
REQ-036 Target=9, start pulsed again in cycle 2, then rst_n pulled low in cycle 3: second start ignored; all outputs 0 and state IDLE immediately; next start completes normally with result=9.
